// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks fetch predictions against execute outcomes and drives predictor update/redirect
// Ports: clock_i/reset_i (async, active-high); trk_* push tracked fetch slots into an in-order FIFO;
// res_* resolve the FIFO head; pc_we_i consumes the held update; update_*/last_br_o train the PHT/BTB;
// wrong_pred_o/fixed_pc_o and wasnt_branch_o/wasnt_br_pc_o redirect fetch; mispred_cnt_o counts
// redirects (saturating); proto_err_o is sticky on a resolve with an empty FIFO.
module branch_resolve_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             trk_valid_i,
    input  logic [31:0]      trk_pc_i,
    input  logic             trk_pred_i,
    input  logic [31:0]      trk_tgt_i,
    output logic             trk_ready_o,
    input  logic             res_valid_i,
    input  logic             res_is_branch_i,
    input  logic             res_taken_i,
    input  logic [31:0]      res_tgt_i,
    output logic             res_ready_o,
    input  logic             pc_we_i,
    output logic [31:0]      update_pc_o,
    output logic [31:0]      update_tgt_o,
    output logic             last_br_o,
    output logic             update_pht_o,
    output logic             update_btb_o,
    output logic             wrong_pred_o,
    output logic [31:0]      fixed_pc_o,
    output logic             wasnt_branch_o,
    output logic [31:0]      wasnt_br_pc_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic             proto_err_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, UPDATE, FLUSH} state_t;
    state_t state, state_nx;
    logic [31:0] pc_mem [DEPTH];
    logic        pred_mem [DEPTH];
    logic [31:0] tgt_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, res_acc, hit, load, redirect, h_pred;
    logic [31:0] h_pc, h_tgt;
    assign trk_ready_o = count != (AW+1)'(DEPTH) && state != FLUSH;
    assign res_ready_o = state == IDLE;
    assign push = trk_valid_i && trk_ready_o;
    assign res_acc = res_valid_i && res_ready_o && count != '0;
    assign h_pc = pc_mem[rd_ptr];
    assign h_pred = pred_mem[rd_ptr];
    assign h_tgt = tgt_mem[rd_ptr];
    // a prediction is correct when the direction matches and, if taken, the target matches too
    assign hit = res_taken_i == h_pred && (!res_taken_i || res_tgt_i == h_tgt);
    // a non-branch slot is only tracked-with-effect when fetch predicted it taken
    assign load = res_acc && (res_is_branch_i || h_pred);
    assign redirect = !res_is_branch_i || !hit;
    always_ff @(posedge clock_i) begin
        if (push) begin
            pc_mem[wr_ptr] <= trk_pc_i;
            pred_mem[wr_ptr] <= trk_pred_i;
            tgt_mem[wr_ptr] <= trk_tgt_i;
        end
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (state == FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= res_acc ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(res_acc);
        end
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE && load) state_nx = UPDATE;
        else if (state == UPDATE && pc_we_i) state_nx = (wrong_pred_o || wasnt_branch_o) ? FLUSH : IDLE;
        else if (state == FLUSH) state_nx = IDLE;
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            update_pc_o <= '0;
            update_tgt_o <= '0;
            last_br_o <= 1'b0;
            update_pht_o <= 1'b0;
            update_btb_o <= 1'b0;
            wrong_pred_o <= 1'b0;
            fixed_pc_o <= '0;
            wasnt_branch_o <= 1'b0;
            wasnt_br_pc_o <= '0;
        end else if (load) begin
            update_pc_o <= res_is_branch_i ? h_pc : '0;
            update_tgt_o <= res_is_branch_i ? res_tgt_i : '0;
            last_br_o <= res_is_branch_i && res_taken_i;
            update_pht_o <= res_is_branch_i;
            update_btb_o <= res_is_branch_i && !hit && res_taken_i;
            wrong_pred_o <= res_is_branch_i && !hit;
            fixed_pc_o <= (res_is_branch_i && !hit) ? (res_taken_i ? res_tgt_i : h_pc + 32'd4) : '0;
            wasnt_branch_o <= !res_is_branch_i;
            wasnt_br_pc_o <= res_is_branch_i ? '0 : h_pc;
        end else if (state == UPDATE && pc_we_i) begin
            update_pc_o <= '0;
            update_tgt_o <= '0;
            last_br_o <= 1'b0;
            update_pht_o <= 1'b0;
            update_btb_o <= 1'b0;
            wrong_pred_o <= 1'b0;
            fixed_pc_o <= '0;
            wasnt_branch_o <= 1'b0;
            wasnt_br_pc_o <= '0;
        end
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            mispred_cnt_o <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (load && redirect && mispred_cnt_o != '1) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            if (res_valid_i && res_ready_o && count == '0) proto_err_o <= 1'b1;
        end
    end
endmodule
